// File: rtl/parity_link_pkg.sv
// Shared definitions for the even-parity inter-board link.
// Used by the transmitter, the receive-side parity checker and the loopback bench.
//   DATA_BITS   payload width carried per frame
//   FRAME_BITS  payload plus parity bit
//   state_t     transmitter FSM states
//   frame_t     {parity, data} word
package parity_link_pkg;

    localparam int DATA_BITS  = 5;
    localparam int FRAME_BITS = 6;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    typedef logic [FRAME_BITS-1:0] frame_t;

    // Bit that makes the XOR of {parity, data} zero.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/parity_generator.sv
// Combinational even-parity bit generator with fault injection.
//   data    payload word
//   inject  1 = invert the generated parity bit
//   parity  bit that makes {parity, data} even (inverted when inject=1)
module parity_generator
    import parity_link_pkg::*;
(
    input  logic [DATA_BITS-1:0] data,
    input  logic                 inject,
    output logic                 parity
);

    assign parity = even_parity(data) ^ inject;

endmodule

// File: rtl/parity_frame_transmitter.sv
// Serializes 5-bit words into start / 6 bits LSB first / stop frames with even parity.
//   clk, rst       system clock, asynchronous active-high reset
//   data_in        payload, sampled on accept
//   parity_inject  sampled on accept; inverts the parity bit
//   data_valid     payload offered
//   data_ready     high only in IDLE
//   serial_out     serial line, idles high
//   frame_out      {parity, data_in} captured at accept
//   busy           high from START through STOP
//   done           one-cycle pulse on the first IDLE cycle after STOP
module parity_frame_transmitter
    import parity_link_pkg::*;
#(
    parameter int BIT_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 parity_inject,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 serial_out,
    output frame_t               frame_out,
    output logic                 busy,
    output logic                 done
);

    localparam int             CW       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [2:0]     IDX_LAST = 3'(FRAME_BITS - 1);

    state_t         state, state_n;
    logic [CW-1:0]  bit_cnt;
    logic [2:0]     idx;
    frame_t         shreg;
    logic           accept, tick, parity, serial_n;

    // data_ready is a registered copy of (state == IDLE), so accept only happens in IDLE.
    assign accept = data_valid && data_ready;
    assign tick   = (bit_cnt == CNT_LAST);

    parity_generator u_pgen (
        .data   (data_in),
        .inject (parity_inject),
        .parity (parity)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (accept) state_n = START;
            START: if (tick) state_n = DATA;
            DATA:  if (tick && idx == IDX_LAST) state_n = STOP;
            STOP:  if (tick) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state change.
    // In DATA the line moves to the next shift-register bit only at a bit boundary;
    // shreg[1] is what shreg[0] becomes after the shift on that same edge.
    always_comb begin
        serial_n = serial_out;
        case (state_n)
            IDLE:  serial_n = 1'b1;
            START: serial_n = 1'b0;
            STOP:  serial_n = 1'b1;
            DATA: begin
                if (state == START)  serial_n = shreg[0];
                else if (tick)       serial_n = shreg[1];
            end
            default: serial_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            serial_out <= 1'b1;
            frame_out  <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            idx        <= '0;
        end else begin
            data_ready <= (state_n == IDLE);
            busy       <= (state_n != IDLE);
            done       <= (state == STOP) && (state_n == IDLE);
            serial_out <= serial_n;

            // Held at zero in IDLE so every frame starts with a full start bit.
            if (state == IDLE || tick) bit_cnt <= '0;
            else                       bit_cnt <= bit_cnt + 1'b1;

            if (accept) begin
                shreg     <= {parity, data_in};
                frame_out <= {parity, data_in};
            end else if (state == DATA && tick) begin
                shreg <= {1'b0, shreg[FRAME_BITS-1:1]};
            end

            if (state == START)            idx <= '0;
            else if (state == DATA && tick) idx <= idx + 3'd1;
        end
    end

endmodule
